output_packet_serializer: RTL and testbench

Parametrised router output stage: accepts whole packets of `WORDS` × `DATA_W` bits from the input buffer, queues up to `DEPTH` of them, and serialises each packet one word per cycle to the downstream port under a valid/ready handshake. It is the successor of the single-packet, fixed 4×8 output buffer. It adds packet queuing, back-pressure with data hold, configurable word order, a last-word marker, overflow reporting and synchronous flush.

---
 rtl/output_packet_serializer_pkg.sv | 29 ++
 rtl/output_packet_serializer_if.sv | 42 ++++
 rtl/output_packet_serializer_packet_slot_fifo.sv | 70 +++++++
 rtl/output_packet_serializer.sv | 110 +++++++++++
 tb/tb_output_packet_serializer.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/output_packet_serializer_pkg.sv
// -----------------------------------------------------------------------------
// RouterPkg
// Shared constants and types for the router output stage.
//   ROUTER_DATA_W / ROUTER_WORDS / ROUTER_OUT_DEPTH : default packet geometry
//   router_packet_t : packet type for the default geometry
//   word_order_e    : which end of the packet is transmitted first
//   src_word_index  : maps a transmit position to the packet word it carries
// -----------------------------------------------------------------------------
package RouterPkg;

    localparam int ROUTER_DATA_W    = 8;
    localparam int ROUTER_WORDS     = 4;
    localparam int ROUTER_OUT_DEPTH = 2;

    // Word WORDS-1 is the most significant word of the packed packet.
    typedef logic [ROUTER_WORDS-1:0][ROUTER_DATA_W-1:0] router_packet_t;

    typedef enum logic {
        ORDER_LSB_FIRST = 1'b0,
        ORDER_MSB_FIRST = 1'b1
    } word_order_e;

    // Position 0 is the first word on the wire; this returns its packet index.
    function automatic int src_word_index(input int pos, input int words,
                                          input word_order_e order);
        return (order == ORDER_MSB_FIRST) ? (words - 1 - pos) : pos;
    endfunction

endpackage

// File: rtl/output_packet_serializer_if.sv
// -----------------------------------------------------------------------------
// output_packet_serializer_if
// Bundles the load side (from the input buffer) and the serial side (to the
// downstream port) of the output serializer.
//   master : drives flush, input_buffer_loaded, data_in, ready_to_receive
//   slave  : drives load_ready, data_routed, overflow, data_transfer_out,
//            output_buffer_data, last_word, pkt_count
// -----------------------------------------------------------------------------
interface output_packet_serializer_if
    import RouterPkg::*;
#(
    parameter int DATA_W = ROUTER_DATA_W,
    parameter int WORDS  = ROUTER_WORDS,
    parameter int DEPTH  = ROUTER_OUT_DEPTH
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic                          flush;
    logic                          input_buffer_loaded;
    logic [WORDS-1:0][DATA_W-1:0]  data_in;
    logic                          load_ready;
    logic                          data_routed;
    logic                          overflow;
    logic                          ready_to_receive;
    logic                          data_transfer_out;
    logic [DATA_W-1:0]             output_buffer_data;
    logic                          last_word;
    logic [CNT_W-1:0]              pkt_count;

    modport master (
        output flush, input_buffer_loaded, data_in, ready_to_receive,
        input  load_ready, data_routed, overflow, data_transfer_out,
               output_buffer_data, last_word, pkt_count
    );

    modport slave (
        input  flush, input_buffer_loaded, data_in, ready_to_receive,
        output load_ready, data_routed, overflow, data_transfer_out,
               output_buffer_data, last_word, pkt_count
    );

endinterface

// File: rtl/output_packet_serializer_packet_slot_fifo.sv
// -----------------------------------------------------------------------------
// packet_slot_fifo
// Circular store of whole packets for the output serializer.
//   clock, reset_n : rising-edge clock, asynchronous active-low reset
//   flush          : synchronous clear of pointers and count
//   push/push_data : write a packet into the tail slot (caller checks load_ready)
//   pop            : release the head slot (caller checks count)
//   head_data      : packet in the head slot
//   count          : number of occupied slots
//   load_ready     : at least one slot is free (registered count only)
// -----------------------------------------------------------------------------
module packet_slot_fifo
    import RouterPkg::*;
#(
    parameter int DATA_W = ROUTER_DATA_W,
    parameter int WORDS  = ROUTER_WORDS,
    parameter int DEPTH  = ROUTER_OUT_DEPTH,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         flush,
    input  logic                         push,
    input  logic [WORDS-1:0][DATA_W-1:0] push_data,
    input  logic                         pop,
    output logic [WORDS-1:0][DATA_W-1:0] head_data,
    output logic [CNT_W-1:0]             count,
    output logic                         load_ready
);

    logic [WORDS-1:0][DATA_W-1:0] slots [DEPTH];
    logic [PTR_W-1:0]             wr_ptr;
    logic [PTR_W-1:0]             rd_ptr;

    // Explicit wrap so DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (pop)  rd_ptr <= next_ptr(rd_ptr);
            // Push and pop together leave the occupancy unchanged.
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Packet storage carries no reset; occupancy alone says what is valid.
    always_ff @(posedge clock) begin
        if (push) slots[wr_ptr] <= push_data;
    end

    assign head_data  = slots[rd_ptr];
    assign load_ready = (count < CNT_W'(DEPTH));

endmodule

// File: rtl/output_packet_serializer.sv
// -----------------------------------------------------------------------------
// output_packet_serializer
// Router output stage: queues whole packets and sends them one word per cycle
// under a valid/ready handshake.
//   clock, reset_n : rising-edge clock, asynchronous active-low reset
//   bus (slave)    : load side  - flush, input_buffer_loaded, data_in,
//                                 load_ready, data_routed, overflow, pkt_count
//                    serial side - ready_to_receive, data_transfer_out,
//                                 output_buffer_data, last_word
// -----------------------------------------------------------------------------
module output_packet_serializer
    import RouterPkg::*;
#(
    parameter int DATA_W    = ROUTER_DATA_W,
    parameter int WORDS     = ROUTER_WORDS,
    parameter int DEPTH     = ROUTER_OUT_DEPTH,
    parameter int MSB_FIRST = 1
) (
    input  logic                        clock,
    input  logic                        reset_n,
    output_packet_serializer_if.slave   bus
);

    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int WPTR_W = $clog2(WORDS);
    localparam word_order_e ORDER = (MSB_FIRST != 0) ? ORDER_MSB_FIRST : ORDER_LSB_FIRST;

    logic [WORDS-1:0][DATA_W-1:0] head_data;
    logic [CNT_W-1:0]             count;
    logic                         load_ready;
    logic                         push;
    logic                         pop;
    logic                         adv;
    logic                         have_pkt;
    logic                         at_last;
    logic [WPTR_W-1:0]            wptr;
    logic [WPTR_W-1:0]            src_idx;

    logic                         out_valid;
    logic [DATA_W-1:0]            out_data;
    logic                         out_last;
    logic                         routed_q;
    logic                         overflow_q;

    packet_slot_fifo #(
        .DATA_W (DATA_W),
        .WORDS  (WORDS),
        .DEPTH  (DEPTH)
    ) u_slots (
        .clock      (clock),
        .reset_n    (reset_n),
        .flush      (bus.flush),
        .push       (push),
        .push_data  (bus.data_in),
        .pop        (pop),
        .head_data  (head_data),
        .count      (count),
        .load_ready (load_ready)
    );

    assign have_pkt = (count != '0);
    assign adv      = !out_valid || bus.ready_to_receive;
    assign at_last  = (wptr == WPTR_W'(WORDS - 1));
    assign src_idx  = WPTR_W'(src_word_index(int'(wptr), WORDS, ORDER));

    // A full queue refuses the load even if the head frees this same edge.
    assign push = bus.input_buffer_loaded && load_ready && !bus.flush;
    // The slot frees on the edge that fetches its last word.
    assign pop  = adv && have_pkt && at_last && !bus.flush;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wptr       <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_last   <= 1'b0;
            routed_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else if (bus.flush) begin
            // Flush wins over any load; the data register keeps its value.
            wptr       <= '0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            routed_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            routed_q   <= push;
            overflow_q <= bus.input_buffer_loaded && !load_ready;
            if (adv) begin
                if (have_pkt) begin
                    out_data  <= head_data[src_idx];
                    out_valid <= 1'b1;
                    out_last  <= at_last;
                    wptr      <= at_last ? '0 : wptr + 1'b1;
                end else begin
                    out_valid <= 1'b0;
                end
            end
        end
    end

    assign bus.load_ready         = load_ready;
    assign bus.pkt_count          = count;
    assign bus.data_routed        = routed_q;
    assign bus.overflow           = overflow_q;
    assign bus.data_transfer_out  = out_valid;
    assign bus.output_buffer_data = out_data;
    assign bus.last_word          = out_last;

endmodule

// File: tb/tb_output_packet_serializer.sv
// -----------------------------------------------------------------------------
// tb_output_packet_serializer
// Drives an MSB-first and an LSB-first serializer with identical stimulus and
// compares both against a packet-queue reference model every cycle.
// -----------------------------------------------------------------------------
module tb_output_packet_serializer;
    import RouterPkg::*;

    localparam int DW = 8;
    localparam int NW = 4;
    localparam int DP = 2;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clock = ~clock;

    output_packet_serializer_if #(.DATA_W(DW), .WORDS(NW), .DEPTH(DP)) bus_m ();
    output_packet_serializer_if #(.DATA_W(DW), .WORDS(NW), .DEPTH(DP)) bus_l ();

    output_packet_serializer #(.DATA_W(DW), .WORDS(NW), .DEPTH(DP), .MSB_FIRST(1)) dut_m (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus_m)
    );

    output_packet_serializer #(.DATA_W(DW), .WORDS(NW), .DEPTH(DP), .MSB_FIRST(0)) dut_l (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus_l)
    );

    // Reference model: a queue of whole packets plus how many words of the
    // head packet have already been handed to the output register.
    router_packet_t m_q[$];
    int             m_taken;
    logic           m_valid, m_last, m_routed, m_ovf;
    logic [DW-1:0]  m_data_m, m_data_l;

    task automatic model_reset();
        m_q.delete();
        m_taken  = 0;
        m_valid  = 1'b0;
        m_last   = 1'b0;
        m_routed = 1'b0;
        m_ovf    = 1'b0;
        m_data_m = '0;
        m_data_l = '0;
    endtask

    task automatic model_edge(input logic ld, input router_packet_t pkt,
                              input logic rdy, input logic fl);
        bit full;
        full = (m_q.size() >= DP);
        if (fl) begin
            m_q.delete();
            m_taken  = 0;
            m_valid  = 1'b0;
            m_last   = 1'b0;
            m_routed = 1'b0;
            m_ovf    = 1'b0;
        end else begin
            if (!m_valid || rdy) begin
                if (m_q.size() > 0) begin
                    m_data_m = m_q[0][NW-1-m_taken];
                    m_data_l = m_q[0][m_taken];
                    m_valid  = 1'b1;
                    m_last   = (m_taken == NW-1);
                    m_taken++;
                    if (m_taken == NW) begin
                        void'(m_q.pop_front());
                        m_taken = 0;
                    end
                end else begin
                    m_valid = 1'b0;
                end
            end
            m_routed = ld && !full;
            m_ovf    = ld && full;
            if (ld && !full) m_q.push_back(pkt);
        end
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs,
                                input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check_output("valid_m", 32'(bus_m.data_transfer_out), 32'(m_valid));
        check_output("valid_l", 32'(bus_l.data_transfer_out), 32'(m_valid));
        if (m_valid) begin
            check_output("data_m", 32'(bus_m.output_buffer_data), 32'(m_data_m));
            check_output("data_l", 32'(bus_l.output_buffer_data), 32'(m_data_l));
            check_output("last_m", 32'(bus_m.last_word), 32'(m_last));
            check_output("last_l", 32'(bus_l.last_word), 32'(m_last));
        end
        check_output("routed",   32'(bus_m.data_routed), 32'(m_routed));
        check_output("overflow", 32'(bus_m.overflow), 32'(m_ovf));
        check_output("pkt_count", 32'(bus_m.pkt_count), 32'(m_q.size()));
        check_output("load_ready", 32'(bus_m.load_ready), 32'(m_q.size() < DP));
        check_output("pkt_count_l", 32'(bus_l.pkt_count), 32'(m_q.size()));
    endtask

    task automatic check_reset_values();
        check_output("rst_valid", 32'(bus_m.data_transfer_out), 32'd0);
        check_output("rst_data", 32'(bus_m.output_buffer_data), 32'd0);
        check_output("rst_last", 32'(bus_m.last_word), 32'd0);
        check_output("rst_routed", 32'(bus_m.data_routed), 32'd0);
        check_output("rst_overflow", 32'(bus_m.overflow), 32'd0);
        check_output("rst_pkt_count", 32'(bus_m.pkt_count), 32'd0);
        check_output("rst_load_ready", 32'(bus_m.load_ready), 32'd1);
        check_output("rst_valid_l", 32'(bus_l.data_transfer_out), 32'd0);
    endtask

    task automatic drive(input logic ld, input router_packet_t pkt,
                         input logic rdy, input logic fl);
        bus_m.input_buffer_loaded = ld;
        bus_m.data_in             = pkt;
        bus_m.ready_to_receive    = rdy;
        bus_m.flush               = fl;
        bus_l.input_buffer_loaded = ld;
        bus_l.data_in             = pkt;
        bus_l.ready_to_receive    = rdy;
        bus_l.flush               = fl;
    endtask

    // One clock: drive, let the edge happen, advance the model, check #1 later.
    task automatic apply_stimulus(input logic ld, input router_packet_t pkt,
                                  input logic rdy, input logic fl);
        drive(ld, pkt, rdy, fl);
        @(posedge clock);
        model_edge(ld, pkt, rdy, fl);
        #1;
        check_all();
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        router_packet_t pa;
        logic [DW-1:0]  exp_m [NW];
        logic [DW-1:0]  exp_l [NW];

        pa = 32'hA3B2C1D0;
        exp_m = '{8'hA3, 8'hB2, 8'hC1, 8'hD0};
        exp_l = '{8'hD0, 8'hC1, 8'hB2, 8'hA3};

        drive(1'b0, '0, 1'b1, 1'b0);
        model_reset();
        #12;
        check_reset_values();
        @(negedge clock);
        reset_n = 1'b1;

        $display("[TB] single packet, ready held high");
        apply_stimulus(1'b1, pa, 1'b1, 1'b0);
        check_output("t1_routed_pulse", 32'(bus_m.data_routed), 32'd1);
        for (int k = 0; k < NW; k++) begin
            apply_stimulus(1'b0, '0, 1'b1, 1'b0);
            check_output("t1_word_m", 32'(bus_m.output_buffer_data), 32'(exp_m[k]));
            check_output("t1_word_l", 32'(bus_l.output_buffer_data), 32'(exp_l[k]));
            check_output("t1_last", 32'(bus_m.last_word), 32'(k == NW-1));
        end
        apply_stimulus(1'b0, '0, 1'b1, 1'b0);

        $display("[TB] back-pressure on second word");
        apply_stimulus(1'b1, pa, 1'b1, 1'b0);
        apply_stimulus(1'b0, '0, 1'b1, 1'b0);
        apply_stimulus(1'b0, '0, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            apply_stimulus(1'b0, '0, 1'b0, 1'b0);
            check_output("t3_hold_data", 32'(bus_m.output_buffer_data), 32'h0000_00B2);
            check_output("t3_hold_valid", 32'(bus_m.data_transfer_out), 32'd1);
        end
        for (int k = 0; k < 3; k++) apply_stimulus(1'b0, '0, 1'b1, 1'b0);

        $display("[TB] queue overflow and back-to-back drain");
        apply_stimulus(1'b1, 32'h11223344, 1'b0, 1'b0);
        apply_stimulus(1'b1, 32'h55667788, 1'b0, 1'b0);
        apply_stimulus(1'b1, 32'h99AABBCC, 1'b0, 1'b0);
        check_output("t4_overflow", 32'(bus_m.overflow), 32'd1);
        check_output("t4_pkt_count", 32'(bus_m.pkt_count), 32'd2);
        check_output("t4_load_ready", 32'(bus_m.load_ready), 32'd0);
        for (int k = 0; k < 2*NW - 1; k++) begin
            apply_stimulus(1'b0, '0, 1'b1, 1'b0);
            check_output("t4_no_bubble", 32'(bus_m.data_transfer_out), 32'd1);
        end
        apply_stimulus(1'b0, '0, 1'b1, 1'b0);

        $display("[TB] flush mid-packet with load");
        apply_stimulus(1'b1, pa, 1'b1, 1'b0);
        apply_stimulus(1'b0, '0, 1'b1, 1'b0);
        apply_stimulus(1'b0, '0, 1'b1, 1'b0);
        apply_stimulus(1'b1, 32'hDEADBEEF, 1'b1, 1'b1);
        check_output("t5_valid", 32'(bus_m.data_transfer_out), 32'd0);
        check_output("t5_pkt_count", 32'(bus_m.pkt_count), 32'd0);
        check_output("t5_routed", 32'(bus_m.data_routed), 32'd0);
        apply_stimulus(1'b0, '0, 1'b1, 1'b0);

        $display("[TB] asynchronous reset mid-packet");
        apply_stimulus(1'b1, 32'h0F1E2D3C, 1'b1, 1'b0);
        apply_stimulus(1'b0, '0, 1'b1, 1'b0);
        apply_stimulus(1'b0, '0, 1'b1, 1'b0);
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check_reset_values();
        @(negedge clock);
        reset_n = 1'b1;
        apply_stimulus(1'b1, pa, 1'b1, 1'b0);
        for (int k = 0; k < NW; k++) begin
            apply_stimulus(1'b0, '0, 1'b1, 1'b0);
            check_output("t6_word_m", 32'(bus_m.output_buffer_data), 32'(exp_m[k]));
        end

        $display("[TB] randomized traffic");
        for (int n = 0; n < 400; n++) begin
            apply_stimulus(1'($urandom_range(0, 1)), router_packet_t'($urandom),
                           1'($urandom_range(0, 3) != 0),
                           1'($urandom_range(0, 49) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
